acorn128_ctrl: RTL and testbench

Phase sequencer for the ACORN-128 bit-serial datapath. It drives the one-step state-update register and its feedback/keystream logic through the full authenticated-encryption flow: state clear, 1792-step key/IV initialisation, associated-data absorption with padding, message encryption with padding, and 768-step finalisation. It generates the per-step `ca`/`cb` controls, the injected message bit and the datapath step enable. It also handshakes bit-serial AD/plaintext streams, emits ciphertext bits and captures the 128-bit tag.

---
 rtl/acorn128_pkg.sv | 25 ++
 rtl/acorn128_init_mux.sv | 24 ++
 rtl/acorn128_ctrl.sv | 150 +++++++++++++++
 tb/tb_acorn128_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// Shared types and phase lengths for the ACORN-128 phase sequencer.
package acorn128_pkg;

  localparam int INIT_STEPS = 1792;
  localparam int PAD_STEPS  = 256;
  localparam int FIN_STEPS  = 768;
  localparam int KEY_W      = 128;
  localparam int TAG_W      = 128;
  localparam int STATE_W    = 293;
  localparam int CNT_W      = 11;
  localparam int TAG_START  = FIN_STEPS - TAG_W;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    INIT,
    AD,
    AD_PAD,
    MSG,
    MSG_PAD,
    FINAL,
    DONE
  } state_t;

endpackage

// File: rtl/acorn128_init_mux.sv
// Injected bit during initialisation: key, then IV, then key[0]^1, then the key repeating.
module acorn128_init_mux
  import acorn128_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] iv,
  input  logic [CNT_W-1:0] i,
  output logic             mbit
);

  logic [6:0] idx;
  assign idx = i[6:0];

  // Offset 256 is a multiple of 128, so (i-256) mod 128 is simply i[6:0].
  always_comb begin
    if (i == CNT_W'(2 * KEY_W))
      mbit = ~key[0];
    else if (i[10:7] == 4'd1)
      mbit = iv[idx];
    else
      mbit = key[idx];
  end

endmodule

// File: rtl/acorn128_ctrl.sv
// Phase sequencer driving the ACORN-128 bit-serial state-update datapath.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | datapath state cleared
// INIT    | 1792 key/IV injection steps
// AD      | one step per accepted associated-data bit
// AD_PAD  | 256 AD padding steps
// MSG     | one step per accepted plaintext bit, ciphertext out
// MSG_PAD | 256 message padding steps (cb=0)
// FINAL   | 768 finalisation steps, last 128 keystream bits form the tag
// DONE    | one-cycle completion pulse
module acorn128_ctrl
  import acorn128_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] iv,
  input  logic             ad_none,
  input  logic             msg_none,
  input  logic             ad_valid,
  input  logic             ad_bit,
  input  logic             ad_last,
  output logic             ad_ready,
  input  logic             msg_valid,
  input  logic             msg_bit,
  input  logic             msg_last,
  output logic             msg_ready,
  input  logic             ks_bit,
  output logic             state_clr,
  output logic             step_en,
  output logic             ca,
  output logic             cb,
  output logic             mbit,
  output logic             ct_valid,
  output logic             ct_bit,
  output logic             busy,
  output logic             done,
  output logic [TAG_W-1:0] tag
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] i;
  logic             ad_none_q, msg_none_q;
  logic             init_mbit;

  acorn128_init_mux u_init_mux (
    .key  (key),
    .iv   (iv),
    .i    (i),
    .mbit (init_mbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= '0;
      tag        <= '0;
      ad_none_q  <= 1'b0;
      msg_none_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        i <= '0;
      else if (step_en)
        i <= i + 1'b1;
      if (state == IDLE && start) begin
        ad_none_q  <= ad_none;
        msg_none_q <= msg_none;
      end
      // TAG_START is a multiple of 128, so i[6:0] is the tag bit index.
      if (state == FINAL && i >= CNT_W'(TAG_START))
        tag[i[6:0]] <= ks_bit;
    end
  end

  always_comb begin
    state_nxt = state;
    state_clr = 1'b0;
    step_en   = 1'b0;
    ca        = 1'b0;
    cb        = 1'b0;
    mbit      = 1'b0;
    ad_ready  = 1'b0;
    msg_ready = 1'b0;
    ct_valid  = 1'b0;
    ct_bit    = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLR;
      end
      CLR: begin
        state_clr = 1'b1;
        state_nxt = INIT;
      end
      INIT: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        mbit    = init_mbit;
        if (i == CNT_W'(INIT_STEPS - 1)) state_nxt = ad_none_q ? AD_PAD : AD;
      end
      AD: begin
        ad_ready = 1'b1;
        step_en  = ad_valid;
        ca       = 1'b1;
        cb       = 1'b1;
        mbit     = ad_valid & ad_bit;
        if (ad_valid && ad_last) state_nxt = AD_PAD;
      end
      AD_PAD, MSG_PAD: begin
        step_en = 1'b1;
        mbit    = (i == '0);
        ca      = (i < CNT_W'(KEY_W));
        cb      = (state == AD_PAD);
        if (i == CNT_W'(PAD_STEPS - 1)) begin
          if (state == MSG_PAD) state_nxt = FINAL;
          else                  state_nxt = msg_none_q ? MSG_PAD : MSG;
        end
      end
      MSG: begin
        msg_ready = 1'b1;
        step_en   = msg_valid;
        ca        = 1'b1;
        mbit      = msg_valid & msg_bit;
        ct_valid  = msg_valid;
        ct_bit    = msg_valid & (msg_bit ^ ks_bit);
        if (msg_valid && msg_last) state_nxt = MSG_PAD;
      end
      FINAL: begin
        step_en = 1'b1;
        ca      = 1'b1;
        cb      = 1'b1;
        if (i == CNT_W'(FIN_STEPS - 1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Directed bench for acorn128_ctrl; the keystream is a known bench pattern indexed by step number.
module tb_acorn128_ctrl;
  import acorn128_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic         ad_none = 1'b0, msg_none = 1'b0;
  logic         ad_valid = 1'b0, ad_bit = 1'b0, ad_last = 1'b0;
  logic         msg_valid = 1'b0, msg_bit = 1'b0, msg_last = 1'b0;
  logic         ad_ready, msg_ready, ks_bit;
  logic         state_clr, step_en, ca, cb, mbit, ct_valid, ct_bit, busy, done;
  logic [127:0] tag;

  always #5 clk = ~clk;

  acorn128_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .ad_none   (ad_none),
    .msg_none  (msg_none),
    .ad_valid  (ad_valid),
    .ad_bit    (ad_bit),
    .ad_last   (ad_last),
    .ad_ready  (ad_ready),
    .msg_valid (msg_valid),
    .msg_bit   (msg_bit),
    .msg_last  (msg_last),
    .msg_ready (msg_ready),
    .ks_bit    (ks_bit),
    .state_clr (state_clr),
    .step_en   (step_en),
    .ca        (ca),
    .cb        (cb),
    .mbit      (mbit),
    .ct_valid  (ct_valid),
    .ct_bit    (ct_bit),
    .busy      (busy),
    .done      (done),
    .tag       (tag)
  );

  logic [127:0] pat = 128'hC3A5_0F1E_9B7D_2468_ACE1_3579_BDF0_5A5A;
  logic         cnt_clr = 1'b0;
  int           step_cnt = 0;

  // Keystream for step k is pat[k mod 128].
  always @(posedge clk)
    if (cnt_clr) step_cnt <= 0;
    else if (step_en) step_cnt <= step_cnt + 1;
  assign ks_bit = pat[step_cnt[6:0]];

  bit mb_a [0:4095];
  bit ca_a [0:4095];
  bit cb_a [0:4095];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic run(input int ad_n, input logic [15:0] ad_d, input int msg_n,
                     input logic [15:0] msg_d, input bit stall, input int abort_at,
                     input int restart_at, output int done_cyc, output int steps,
                     output int bad, output logic [15:0] ct_got);
    int ai, mi, cyc;
    bit fin;
    ai = 0; mi = 0; cyc = 0; fin = 0;
    done_cyc = -1; steps = 0; bad = 0; ct_got = '0;
    @(negedge clk);
    start = 1'b1; ad_none = (ad_n == 0); msg_none = (msg_n == 0); cnt_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt_clr = 1'b0; cyc = 1;
    while (!fin && cyc < 8000) begin
      start     = (cyc == restart_at);
      ad_valid  = (ai < ad_n) && !(stall && $urandom_range(0, 2) == 0);
      ad_bit    = (ai < ad_n) ? ad_d[ai] : 1'b0;
      ad_last   = (ai == ad_n - 1);
      msg_valid = (mi < msg_n) && !(stall && $urandom_range(0, 2) == 0);
      msg_bit   = (mi < msg_n) ? msg_d[mi] : 1'b0;
      msg_last  = (mi == msg_n - 1);
      #1;
      if (cyc == 1 && !(state_clr && !step_en)) bad++;
      if (cyc > 1 && state_clr) bad++;
      if (!done && !busy) bad++;
      if (ad_ready && !ad_valid && step_en) bad++;
      if (msg_ready && !msg_valid && step_en) bad++;
      if (ct_valid != (msg_valid && msg_ready)) bad++;
      if (ad_valid && ad_ready) ai++;
      if (msg_valid && msg_ready) begin
        ct_got[mi] = ct_bit;
        mi++;
      end
      if (step_en && steps < 4096) begin
        mb_a[steps] = mbit;
        ca_a[steps] = ca;
        cb_a[steps] = cb;
        if (steps == abort_at) begin
          rst_n = 1'b0;
          fin = 1;
        end
        steps++;
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; ad_valid = 1'b0; msg_valid = 1'b0; ad_last = 1'b0; msg_last = 1'b0;
    if (abort_at < 0) begin
      repeat (4) begin
        #1;
        if (done || busy) bad++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int dc, st, bad, e_ca, e_cb, e_mb;
    logic [15:0]  ctg, ct_exp;
    logic [15:0]  ad_d, msg_d;
    logic [127:0] v, tag_exp;

    key = 128'h1;
    iv  = '1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {state_clr, step_en, ca, cb, mbit, ct_valid, ct_bit,
                            ad_ready, msg_ready, busy, done}, '0);
    check("reset_tag", tag, '0);
    rst_n = 1'b1;

    run(0, 16'h0, 0, 16'h0, 0, -1, -1, dc, st, bad, ctg);
    check("empty_done_cycle", dc, 3074);
    check("empty_step_count", st, 3072);
    check("empty_protocol", bad, 0);
    check("empty_tag", tag, pat);

    v = '0;
    for (int k = 1; k < 128; k++) v[k-1] = mb_a[k];
    check("init_key_bits_1_127", v, '0);
    for (int k = 128; k < 256; k++) v[k-128] = mb_a[k];
    check("init_iv_bits", v, '1);
    check("init_i0", mb_a[0], 1);
    check("init_i256", mb_a[256], 0);
    check("init_i257", mb_a[257], 0);
    check("init_i384", mb_a[384], 1);

    e_ca = 0; e_cb = 0; e_mb = 0;
    for (int k = 0; k < 256; k++) begin
      if (ca_a[1792+k] != (k < 128)) e_ca++;
      if (cb_a[1792+k] != 1'b1) e_cb++;
      if (mb_a[1792+k] != (k == 0)) e_mb++;
    end
    check("adpad_ca", e_ca, 0);
    check("adpad_cb", e_cb, 0);
    check("adpad_mbit", e_mb, 0);
    e_ca = 0; e_cb = 0; e_mb = 0;
    for (int k = 0; k < 256; k++) begin
      if (ca_a[2048+k] != (k < 128)) e_ca++;
      if (cb_a[2048+k] != 1'b0) e_cb++;
      if (mb_a[2048+k] != (k == 0)) e_mb++;
    end
    check("msgpad_ca", e_ca, 0);
    check("msgpad_cb", e_cb, 0);
    check("msgpad_mbit", e_mb, 0);
    e_mb = 0;
    for (int k = 0; k < 768; k++)
      if (mb_a[2304+k] != 1'b0 || ca_a[2304+k] != 1'b1 || cb_a[2304+k] != 1'b1) e_mb++;
    check("final_controls", e_mb, 0);

    // 8 AD bits and 16 plaintext bits with random valid gaps.
    key = 128'h0123_4567_89AB_CDEF_0F0F_F0F0_AAAA_5555;
    iv  = 128'h1;
    ad_d  = 16'h00A5;
    msg_d = 16'h1234;
    run(8, ad_d, 16, msg_d, 1, -1, -1, dc, st, bad, ctg);
    check("admsg_step_count", st, 3096);
    check("admsg_protocol", bad, 0);
    if (dc < 3098) check("admsg_done_cycle", dc, 3098);
    e_mb = 0;
    for (int k = 0; k < 8; k++) if (mb_a[1792+k] != ad_d[k]) e_mb++;
    for (int k = 0; k < 16; k++)
      if (mb_a[2056+k] != msg_d[k] || ca_a[2056+k] != 1'b1 || cb_a[2056+k] != 1'b0) e_mb++;
    check("admsg_injection", e_mb, 0);
    for (int k = 0; k < 16; k++) ct_exp[k] = msg_d[k] ^ pat[8+k];
    check("admsg_ciphertext", ctg, ct_exp);
    for (int j = 0; j < 128; j++) tag_exp[j] = pat[(j + 24) % 128];
    check("admsg_tag", tag, tag_exp);

    // Reset during FINAL at i=300 (global step 2304+300).
    run(0, 16'h0, 0, 16'h0, 0, 2604, -1, dc, st, bad, ctg);
    #1;
    check("abort_outputs", {state_clr, step_en, ca, cb, mbit, ct_valid, ct_bit,
                            ad_ready, msg_ready, busy, done}, '0);
    check("abort_tag", tag, '0);
    rst_n = 1'b1;
    run(0, 16'h0, 0, 16'h0, 0, -1, -1, dc, st, bad, ctg);
    check("rerun_done_cycle", dc, 3074);
    check("rerun_protocol", bad, 0);
    check("rerun_tag", tag, pat);

    // start pulsed mid-INIT must be ignored.
    run(0, 16'h0, 0, 16'h0, 0, -1, 100, dc, st, bad, ctg);
    check("restart_done_cycle", dc, 3074);
    check("restart_step_count", st, 3072);
    check("restart_protocol", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
